// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
// Single-port data memory for the MEM stage with a valid/ready request
// interface, a registered one-cycle read path and a sequential init engine
// that rewrites the power-on pattern one word per cycle.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-high reset (restarts the init sweep)
//   init_req   synchronous request to re-run the init sweep (IDLE only)
//   req_valid  request present
//   req_ready  block accepts a request this cycle (IDLE)
//   req_we     1 = write, 0 = read
//   req_addr   word address; addresses >= DEPTH are flagged, never aliased
//   req_wdata  write data
//   rd_valid   one-cycle pulse, rd_data holds the read result
//   rd_data    read result, holds its last value between pulses
//   err        one-cycle pulse for an accepted out-of-range request
//   init_done  memory initialised and block IDLE
module data_memory_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              init_req,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              err,
    output logic              init_done
);

    localparam int KW = $clog2(DEPTH);
    localparam logic [KW-1:0]   LAST_K  = KW'(DEPTH - 1);
    localparam logic [KW-1:0]   HALF_K  = KW'(DEPTH / 2);
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     k, k_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] init_word;
    logic [KW-1:0]     idx;
    logic              accept;
    logic              in_range;

    assign req_ready = (state == IDLE);
    assign init_done = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_A);
    assign idx       = req_addr[KW-1:0];

    // Lower half of the array counts up from 0, upper half counts down
    // from 0 in two's complement (0, -1, -2, ...).
    always_comb begin
        init_word = '0;
        if (k < HALF_K)
            init_word = DATA_W'(k);
        else
            init_word = DATA_W'(DEPTH / 2) - DATA_W'(k);
    end

    // Next-state logic. A request accepted alongside init_req still
    // completes through the output registers; the sweep starts after it.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        case (state)
            INIT: begin
                if (k == LAST_K) begin
                    state_nxt = IDLE;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            IDLE: begin
                if (init_req) begin
                    state_nxt = INIT;
                    k_nxt     = '0;
                end
            end
            default: begin
                state_nxt = INIT;
                k_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= INIT;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // Storage array has no reset; the init sweep owns it while in INIT.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[k] <= init_word;
        else if (accept && req_we && in_range)
            mem[idx] <= req_wdata;
    end

    // Registered read/err path. Out-of-range reads return zero rather
    // than an aliased word.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_valid <= 1'b0;
            err      <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= accept && !req_we;
            err      <= accept && !in_range;
            if (accept && !req_we)
                rd_data <= in_range ? mem[idx] : '0;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl
// Directed, table-driven bench for data_memory_ctrl (DATA_W=8, DEPTH=32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_data_memory_ctrl;

    logic       clk;
    logic       clr;
    logic       init_req;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       err;
    logic       init_done;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       exp_rv;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_mem [32];

    data_memory_ctrl #(.DATA_W(8), .DEPTH(32), .ADDR_W(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .init_req  (init_req),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .err       (err),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
    endtask

    task automatic checkOutput(input vec_t v, input int i);
        check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(v.exp_rv));
        check($sformatf("vec%0d err", i), 32'(err), 32'(v.exp_err));
        if (v.exp_rv)
            check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(v.exp_rd));
    endtask

    task automatic idleInputs();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        init_req  = 1'b0;
    endtask

    function automatic vec_t rd(input logic [7:0] a, input logic [7:0] d, input logic e);
        vec_t v;
        v.we = 1'b0; v.addr = a; v.wdata = 8'h00;
        v.exp_rv = 1'b1; v.exp_rd = d; v.exp_err = e;
        return v;
    endfunction

    function automatic vec_t wr(input logic [7:0] a, input logic [7:0] d, input logic e);
        vec_t v;
        v.we = 1'b1; v.addr = a; v.wdata = d;
        v.exp_rv = 1'b0; v.exp_rd = 8'h00; v.exp_err = e;
        return v;
    endfunction

    // Count init cycles after clr release: ready stays low for 31 samples,
    // rises on the 32nd.
    task automatic waitInit(input string name);
        int early;
        early = 0;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            if (req_ready || init_done || rd_valid || err) early++;
        end
        check({name, " quiet during INIT"}, 32'(early), 32'd0);
        @(negedge clk);
        check({name, " req_ready after 32"}, 32'(req_ready), 32'd1);
        check({name, " init_done after 32"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        int ignored;
        clr = 1'b1;
        idleInputs();

        // Power-on pattern model: 0..15, then 0,-1,...,-15
        for (int a = 0; a < 16; a++) exp_mem[a] = 8'(a);
        for (int a = 16; a < 32; a++) exp_mem[a] = 8'(256 - (a - 16)) ;
        exp_mem[16] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset init_done", 32'(init_done), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);

        // Init timing with a read held on the bus that must be ignored
        clr       = 1'b0;
        req_valid = 1'b1;
        req_addr  = 8'd7;
        waitInit("power-on");
        idleInputs();

        // Vector table: spot reads, throughput, write/read, out-of-range, dump
        vecs.push_back(rd(8'd5,  8'h05, 1'b0));
        vecs.push_back(rd(8'd16, 8'h00, 1'b0));
        vecs.push_back(rd(8'd21, 8'hFB, 1'b0));
        vecs.push_back(rd(8'd31, 8'hF1, 1'b0));
        vecs.push_back(rd(8'd0,  8'h00, 1'b0));
        vecs.push_back(rd(8'd1,  8'h01, 1'b0));
        vecs.push_back(rd(8'd2,  8'h02, 1'b0));
        vecs.push_back(rd(8'd3,  8'h03, 1'b0));
        vecs.push_back(wr(8'd3,  8'hA5, 1'b0));
        vecs.push_back(rd(8'd3,  8'hA5, 1'b0));
        vecs.push_back(rd(8'd4,  8'h04, 1'b0));
        vecs.push_back(rd(8'd40, 8'h00, 1'b1));
        vecs.push_back(wr(8'd40, 8'h77, 1'b1));
        exp_mem[3] = 8'hA5;
        for (int a = 0; a < 32; a++) vecs.push_back(rd(8'(a), exp_mem[a], 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (i > 0) checkOutput(vecs[i-1], i - 1);
            applyStimulus(vecs[i]);
        end
        @(negedge clk);
        checkOutput(vecs[vecs.size()-1], vecs.size() - 1);
        idleInputs();
        @(negedge clk);
        check("idle rd_valid low", 32'(rd_valid), 32'd0);
        check("idle rd_data holds", 32'(rd_data), 32'(exp_mem[31]));

        // Re-init with a simultaneous read of addr 3
        init_req  = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'd3;
        @(negedge clk);
        idleInputs();
        check("reinit read rd_valid", 32'(rd_valid), 32'd1);
        check("reinit read rd_data", 32'(rd_data), 32'hA5);
        check("reinit req_ready low", 32'(req_ready), 32'd0);
        check("reinit init_done low", 32'(init_done), 32'd0);
        ignored = 0;
        for (int c = 2; c <= 32; c++) begin
            init_req = (c == 10);
            @(negedge clk);
            if (req_ready || rd_valid || err) ignored++;
        end
        init_req = 1'b0;
        check("reinit quiet 32 cycles", 32'(ignored), 32'd0);
        @(negedge clk);
        check("reinit req_ready back", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = 8'd3;
        @(negedge clk);
        idleInputs();
        check("reinit addr3 rd_valid", 32'(rd_valid), 32'd1);
        check("reinit addr3 rd_data", 32'(rd_data), 32'h03);

        // clr at k = 10 restarts the sweep
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (10) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check("mid-init clr init_done", 32'(init_done), 32'd0);
        clr = 1'b0;
        waitInit("mid-init clr");

        // clr in the cycle after a read accept
        req_valid = 1'b1;
        req_addr  = 8'd5;
        @(posedge clk);
        #1;
        idleInputs();
        clr = 1'b1;
        @(negedge clk);
        check("clr after read rd_valid", 32'(rd_valid), 32'd0);
        check("clr after read rd_data", 32'(rd_data), 32'd0);
        check("clr after read req_ready", 32'(req_ready), 32'd0);
        clr = 1'b0;
        waitInit("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
